fir_da_sequencer: RTL

//  Parametrised control sequencer for the distributed-arithmetic (DA) FIR datapath.

---
 rtl/fir_da_sequencer_if.sv | 71 +++++++
 rtl/fir_da_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_da_sequencer_if.sv
// fir_da_sequencer_if
// Purpose: groups the coefficient-load, sample handshake and DA-engine control
//          signals of the DA FIR sequencer into one bundle.
// Ports (signals):
//   cload, coef_valid, valid_in          source/loader -> sequencer
//   coef_we, coef_addr                   coefficient RAM write port
//   in_ready, enable_fifo, resetn_fifo   sample handshake and FIFO control
//   reset_da, resetn_da, start_da,
//   da_bit_idx, da_last_bit, ch_sel      bit-serial DA engine control
//   global_valid_out, out_ch             per-channel result strobe and tag
//   err_overrun                          sticky overrun flag
//   sample_cnt, state_dbg                only with FIR_SEQ_STATUS_EN defined
// Modports: master = source/loader side, slave = sequencer side.
interface fir_da_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int NTAPS  = 8
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic          cload;
    logic          coef_valid;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic          valid_in;
    logic          in_ready;
    logic          enable_fifo;
    logic          resetn_fifo;
    logic          reset_da;
    logic          resetn_da;
    logic          start_da;
    logic [BW-1:0] da_bit_idx;
    logic          da_last_bit;
    logic [CW-1:0] ch_sel;
    logic          global_valid_out;
    logic [CW-1:0] out_ch;
    logic          err_overrun;

`ifdef FIR_SEQ_STATUS_EN
    logic [15:0]   sample_cnt;
    logic [2:0]    state_dbg;

    modport master (
        output cload, coef_valid, valid_in,
        input  coef_we, coef_addr, in_ready, enable_fifo, resetn_fifo, reset_da,
               resetn_da, start_da, da_bit_idx, da_last_bit, ch_sel,
               global_valid_out, out_ch, err_overrun, sample_cnt, state_dbg
    );
    modport slave (
        input  cload, coef_valid, valid_in,
        output coef_we, coef_addr, in_ready, enable_fifo, resetn_fifo, reset_da,
               resetn_da, start_da, da_bit_idx, da_last_bit, ch_sel,
               global_valid_out, out_ch, err_overrun, sample_cnt, state_dbg
    );
`else
    modport master (
        output cload, coef_valid, valid_in,
        input  coef_we, coef_addr, in_ready, enable_fifo, resetn_fifo, reset_da,
               resetn_da, start_da, da_bit_idx, da_last_bit, ch_sel,
               global_valid_out, out_ch, err_overrun
    );
    modport slave (
        input  cload, coef_valid, valid_in,
        output coef_we, coef_addr, in_ready, enable_fifo, resetn_fifo, reset_da,
               resetn_da, start_da, da_bit_idx, da_last_bit, ch_sel,
               global_valid_out, out_ch, err_overrun
    );
`endif
endinterface

// File: rtl/fir_da_sequencer.sv
// fir_da_sequencer
// Purpose: control sequencer for a distributed-arithmetic FIR datapath. Loads NTAPS
//          coefficient words, accepts one sample at a time, steps the bit-serial DA
//          engine through DATA_W bits for each of NUM_CH channels, and tags each
//          channel result valid PIPE_LAT cycles after its last bit.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     fir_da_sequencer_if.slave (see interface file for the signal list)
// Option: FIR_SEQ_STATUS_EN adds bus.sample_cnt (completed samples) and
//         bus.state_dbg (IDLE=0, LOAD=1, READY=2, RUN=3, FLUSH=4).
//
// state | meaning
// IDLE  | after reset, DA and FIFO held in reset, waiting for cload
// LOAD  | writing NTAPS coefficient words, one per coef_valid
// READY | in_ready high, waiting for a sample
// RUN   | bit-serial processing, DATA_W cycles per channel
// FLUSH | PIPE_LAT cycles draining the DA output pipeline
module fir_da_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int NTAPS    = 8,
    parameter int PIPE_LAT = 2
) (
    input logic                 clk,
    input logic                 resetn,
    fir_da_sequencer_if.slave   bus
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] word_cnt;
    logic          coef_we_q;
    logic [AW-1:0] coef_addr_q;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] ch_cnt;
    logic [FW-1:0] flush_cnt;
    logic [PIPE_LAT-1:0] vld_pipe;
    logic [CW-1:0] ch_pipe [PIPE_LAT];
    logic          err_q;

    logic in_ready_c, enable_fifo_c, resetn_fifo_c, reset_da_c, resetn_da_c;
    logic start_da_c, da_last_c;

    wire bit_last   = (bit_cnt == BW'(DATA_W - 1));
    wire ch_last    = (ch_cnt == CW'(NUM_CH - 1));
    wire word_last  = (word_cnt == AW'(NTAPS - 1));
    wire flush_done = (flush_cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Outputs depend on state and counters only; inputs only steer state_nxt.
    always_comb begin
        state_nxt     = state;
        in_ready_c    = 1'b0;
        enable_fifo_c = 1'b0;
        resetn_fifo_c = 1'b0;
        reset_da_c    = 1'b1;
        resetn_da_c   = 1'b1;
        start_da_c    = 1'b0;
        da_last_c     = 1'b0;
        case (state)
            S_IDLE: begin
                resetn_da_c = 1'b0;
                if (bus.cload) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (!bus.cload && bus.coef_valid && word_last) state_nxt = S_READY;
            end
            S_READY: begin
                in_ready_c    = 1'b1;
                resetn_fifo_c = 1'b1;
                if (bus.cload)         state_nxt = S_LOAD;
                else if (bus.valid_in) state_nxt = S_RUN;
            end
            S_RUN: begin
                resetn_fifo_c = 1'b1;
                reset_da_c    = 1'b0;
                start_da_c    = (bit_cnt == '0);
                da_last_c     = bit_last;
                enable_fifo_c = (bit_cnt == '0) && (ch_cnt == '0);
                if (bus.cload)                state_nxt = S_LOAD;
                else if (bit_last && ch_last) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                resetn_fifo_c = 1'b1;
                reset_da_c    = 1'b0;
                if (bus.cload)       state_nxt = S_LOAD;
                else if (flush_done) state_nxt = S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt    <= '0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            bit_cnt     <= '0;
            ch_cnt      <= '0;
            flush_cnt   <= '0;
            vld_pipe    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) ch_pipe[i] <= '0;
        end else begin
            // The write strobe is registered, so the NTAPS-th word is written in the
            // first READY cycle.
            coef_we_q <= 1'b0;
            if (bus.cload) begin
                word_cnt <= '0;
            end else if (state == S_LOAD && bus.coef_valid) begin
                coef_we_q   <= 1'b1;
                coef_addr_q <= word_cnt;
                word_cnt    <= word_last ? '0 : word_cnt + 1'b1;
            end

            // Bit/channel counters sit at zero outside RUN, so every RUN entry starts clean.
            if (state == S_RUN && !bus.cload) begin
                if (bit_last) begin
                    bit_cnt <= '0;
                    ch_cnt  <= ch_last ? '0 : ch_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= '0;
                ch_cnt  <= '0;
            end

            if (state == S_FLUSH) flush_cnt <= flush_cnt - 1'b1;
            else                  flush_cnt <= FW'(PIPE_LAT - 1);

            // An abort drops every result still in flight.
            if (bus.cload) begin
                vld_pipe <= '0;
                for (int i = 0; i < PIPE_LAT; i++) ch_pipe[i] <= '0;
            end else begin
                vld_pipe[0] <= da_last_c;
                ch_pipe[0]  <= ch_cnt;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    ch_pipe[i]  <= ch_pipe[i-1];
                end
            end

            if (bus.cload)                          err_q <= 1'b0;
            else if (bus.valid_in && !in_ready_c)   err_q <= 1'b1;
        end
    end

    assign bus.coef_we          = coef_we_q;
    assign bus.coef_addr        = coef_addr_q;
    assign bus.in_ready         = in_ready_c;
    assign bus.enable_fifo      = enable_fifo_c;
    assign bus.resetn_fifo      = resetn_fifo_c;
    assign bus.reset_da         = reset_da_c;
    assign bus.resetn_da        = resetn_da_c;
    assign bus.start_da         = start_da_c;
    assign bus.da_bit_idx       = bit_cnt;
    assign bus.da_last_bit      = da_last_c;
    assign bus.ch_sel           = ch_cnt;
    assign bus.global_valid_out = vld_pipe[PIPE_LAT-1];
    assign bus.out_ch           = ch_pipe[PIPE_LAT-1];
    assign bus.err_overrun      = err_q;

`ifdef FIR_SEQ_STATUS_EN
    logic [15:0] sample_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            sample_cnt_q <= '0;
        else if (bus.cload)
            sample_cnt_q <= '0;
        else if (vld_pipe[PIPE_LAT-1] && ch_pipe[PIPE_LAT-1] == CW'(NUM_CH - 1))
            sample_cnt_q <= sample_cnt_q + 16'd1;
    end

    assign bus.sample_cnt = sample_cnt_q;
    assign bus.state_dbg  = state;
`endif
endmodule
